// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared types and default widths for the LC-3b memory arbiter.
package lc3b_types;

  localparam int DEF_NUM_CH = 2;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/lc3b_mem_arbiter_if.sv
// Client-side and memory-side bus of the arbiter, bundled for port connection.
interface lc3b_mem_arbiter_if
  import lc3b_types::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  localparam int MASK_W = DATA_W / 8;

  // Handshake: a client holds ch_read/ch_write (level) with stable address,
  // data and mask until its ch_resp bit pulses for exactly one cycle; that
  // pulse is the only cycle in which ch_rdata is meaningful to the client.
  // Toward memory, mem_read/mem_write stay high until mem_resp pulses.
  logic [NUM_CH-1:0]             ch_read;
  logic [NUM_CH-1:0]             ch_write;
  logic [NUM_CH-1:0][MASK_W-1:0] ch_byte_enable;
  logic [NUM_CH-1:0][ADDR_W-1:0] ch_address;
  logic [NUM_CH-1:0][DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]             ch_resp;
  logic [DATA_W-1:0]             ch_rdata;

  logic                          mem_read;
  logic                          mem_write;
  logic [MASK_W-1:0]             mem_byte_enable;
  logic [ADDR_W-1:0]             mem_address;
  logic [DATA_W-1:0]             mem_wdata;
  logic                          mem_resp;
  logic [DATA_W-1:0]             mem_rdata;

  modport master (
    input  ch_read, ch_write, ch_byte_enable, ch_address, ch_wdata,
    input  mem_resp, mem_rdata,
    output ch_resp, ch_rdata,
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
  );

  modport slave (
    output ch_read, ch_write, ch_byte_enable, ch_address, ch_wdata,
    output mem_resp, mem_rdata,
    input  ch_resp, ch_rdata,
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
  );

endinterface

// File: rtl/lc3b_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module rr_picker #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] index
);

  logic [PTR_W-1:0] cand;

  // Walk from farthest to nearest so the closest requester to ptr wins last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = PTR_W'((32'(ptr) + 32'(i)) % N);
      if (req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// Round-robin arbiter sharing one physical memory port among NUM_CH clients.
module lc3b_mem_arbiter
  import lc3b_types::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  localparam int MASK_W = DATA_W / 8,
  localparam int PTR_W  = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  lc3b_mem_arbiter_if.master  bus,
  output arb_state_t          state_dbg,
  output logic [PTR_W-1:0]    rr_ptr_dbg,
  output logic [PTR_W-1:0]    grant_dbg
);

  arb_state_t        state, state_nxt;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  grant_q;
  logic              op_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] be_q;

  logic [NUM_CH-1:0] req;
  logic              pick_valid;
  logic [PTR_W-1:0]  pick_idx;

  assign req = bus.ch_read | bus.ch_write;

  rr_picker #(
    .N     (NUM_CH),
    .PTR_W (PTR_W)
  ) u_picker (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  always_comb begin
    state_nxt   = state;
    bus.ch_resp = '0;
    case (state)
      IDLE:    if (pick_valid) state_nxt = BUSY;
      BUSY: begin
        if (bus.mem_resp) begin
          bus.ch_resp[grant_q] = 1'b1;
          state_nxt            = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write wins when a client raises read and write together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_q    <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_valid) begin
        grant_q    <= pick_idx;
        op_write_q <= bus.ch_write[pick_idx];
        addr_q     <= bus.ch_address[pick_idx];
        wdata_q    <= bus.ch_wdata[pick_idx];
        be_q       <= bus.ch_byte_enable[pick_idx];
      end
      if (state == BUSY && bus.mem_resp) begin
        rr_ptr <= (grant_q == PTR_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
      end
    end
  end

  assign bus.mem_read        = (state == BUSY) && !op_write_q;
  assign bus.mem_write       = (state == BUSY) && op_write_q;
  assign bus.mem_address     = addr_q;
  assign bus.mem_wdata       = wdata_q;
  assign bus.mem_byte_enable = be_q;
  assign bus.ch_rdata        = bus.mem_rdata;

  assign state_dbg  = state;
  assign rr_ptr_dbg = rr_ptr;
  assign grant_dbg  = grant_q;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Directed self-checking bench for lc3b_mem_arbiter with four clients.
module tb_lc3b_mem_arbiter;
  import lc3b_types::*;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int PTR_W  = 2;

  logic clk;
  logic rst_n;
  arb_state_t       state_dbg;
  logic [PTR_W-1:0] rr_ptr_dbg;
  logic [PTR_W-1:0] grant_dbg;

  logic              auto_resp;
  logic              stray_resp;
  logic [DATA_W-1:0] mem_rd_val;
  int                mem_lat;
  int                wait_cnt;

  int n_checks;
  int n_errors;
  logic [NUM_CH-1:0] exp_q[$];

  lc3b_mem_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  lc3b_mem_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .state_dbg  (state_dbg),
    .rr_ptr_dbg (rr_ptr_dbg),
    .grant_dbg  (grant_dbg)
  );

  assign bus.mem_resp  = auto_resp | stray_resp;
  assign bus.mem_rdata = mem_rd_val;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.ch_read   = '0;
    bus.ch_write  = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_resp(input string tag, output int n);
    n = 0;
    while (bus.ch_resp == '0 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_resp_seen"}, 32'(bus.ch_resp != '0), 32'd1);
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (state_dbg != BUSY && n < 10) begin
      step();
      n++;
    end
    check({tag, "_busy_reached"}, 32'(state_dbg == BUSY), 32'd1);
  endtask

  // memory model: responds on the mem_lat-th cycle of a strobe
  initial begin
    auto_resp = 1'b0;
    wait_cnt  = 0;
    forever begin
      @(negedge clk);
      auto_resp = 1'b0;
      if (bus.mem_read === 1'b1 || bus.mem_write === 1'b1) begin
        if (wait_cnt >= mem_lat - 1) begin
          auto_resp = 1'b1;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // scoreboard: every ch_resp pulse must match the next expected grant
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus.ch_resp !== '0 && rst_n === 1'b1) begin
        if (exp_q.size() == 0) check("resp_unexpected", 32'(bus.ch_resp), 32'd0);
        else check("resp_grant", 32'(bus.ch_resp), 32'(exp_q.pop_front()));
        check("resp_rdata", 32'(bus.ch_rdata), 32'(mem_rd_val));
      end
    end
  end

  // driver / directed tests
  initial begin
    int n;
    int g;
    n_checks           = 0;
    n_errors           = 0;
    rst_n              = 1'b0;
    stray_resp         = 1'b0;
    mem_rd_val         = '0;
    mem_lat            = 1;
    bus.ch_read        = '0;
    bus.ch_write       = '0;
    bus.ch_byte_enable = '0;
    bus.ch_address     = '0;
    bus.ch_wdata       = '0;

    // reset state
    do_reset();
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_rr_ptr", 32'(rr_ptr_dbg), 32'd0);
    check("rst_grant", 32'(grant_dbg), 32'd0);
    check("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check("rst_addr", 32'(bus.mem_address), 32'd0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_be", 32'(bus.mem_byte_enable), 32'd0);
    check("rst_ch_resp", 32'(bus.ch_resp), 32'd0);

    // single read on ch1, memory answers in the third strobe cycle
    mem_lat           = 3;
    mem_rd_val        = 16'hBEEF;
    bus.ch_address[1] = 16'h1234;
    bus.ch_read       = 4'b0010;
    exp_q.push_back(4'b0010);
    check("rd_idle_strobe", 32'(bus.mem_read), 32'd0);
    check("rd_passthru", 32'(bus.ch_rdata), 32'hBEEF);
    step();
    check("rd_strobe", 32'(bus.mem_read), 32'd1);
    check("rd_no_write", 32'(bus.mem_write), 32'd0);
    check("rd_addr", 32'(bus.mem_address), 32'h1234);
    check("rd_grant", 32'(grant_dbg), 32'd1);
    wait_resp("rd", n);
    check("rd_latency", 32'(n), 32'd2);
    check("rd_resp", 32'(bus.ch_resp), 32'b0010);
    check("rd_rdata", 32'(bus.ch_rdata), 32'hBEEF);
    bus.ch_read = '0;
    step();
    check("rd_release", 32'(state_dbg), 32'(RELEASE));
    check("rd_rel_strobe", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check("rd_rel_resp", 32'(bus.ch_resp), 32'd0);
    check("rd_rr_ptr", 32'(rr_ptr_dbg), 32'd2);
    step();

    // reset in the middle of a BUSY read on ch2 (rr_ptr is 2 here)
    mem_lat           = 5;
    bus.ch_address[2] = 16'h0300;
    bus.ch_read       = 4'b0100;
    step();
    check("mr_strobe", 32'(bus.mem_read), 32'd1);
    check("mr_grant", 32'(grant_dbg), 32'd2);
    step();
    check("mr_still_busy", 32'(state_dbg), 32'(BUSY));
    rst_n = 1'b0;
    step();
    check("mr_strobes_off", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check("mr_no_resp", 32'(bus.ch_resp), 32'd0);
    check("mr_rr_ptr", 32'(rr_ptr_dbg), 32'd0);
    check("mr_state", 32'(state_dbg), 32'(IDLE));
    check("mr_addr", 32'(bus.mem_address), 32'd0);
    bus.ch_read = '0;
    step();
    rst_n = 1'b1;
    step();

    // masked write on ch0
    mem_lat              = 1;
    bus.ch_address[0]     = 16'h0041;
    bus.ch_wdata[0]       = 16'hAB00;
    bus.ch_byte_enable[0] = 2'b10;
    bus.ch_write          = 4'b0001;
    exp_q.push_back(4'b0001);
    step();
    check("wr_strobe", 32'(bus.mem_write), 32'd1);
    check("wr_no_read", 32'(bus.mem_read), 32'd0);
    check("wr_be", 32'(bus.mem_byte_enable), 32'b10);
    check("wr_wdata", 32'(bus.mem_wdata), 32'hAB00);
    check("wr_addr", 32'(bus.mem_address), 32'h0041);
    check("wr_resp", 32'(bus.ch_resp), 32'b0001);
    bus.ch_write = '0;
    step();
    check("wr_rel_strobe", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check("wr_rr_ptr", 32'(rr_ptr_dbg), 32'd1);
    step();

    // read+write together on ch0 with a stray mem_resp while IDLE
    mem_lat               = 2;
    mem_rd_val            = 16'h0F0F;
    bus.ch_address[0]     = 16'h0042;
    bus.ch_wdata[0]       = 16'h1234;
    bus.ch_byte_enable[0] = 2'b11;
    bus.ch_read           = 4'b0001;
    bus.ch_write          = 4'b0001;
    stray_resp            = 1'b1;
    exp_q.push_back(4'b0001);
    #1;
    check("stray_no_resp", 32'(bus.ch_resp), 32'd0);
    #1;
    stray_resp = 1'b0;
    step();
    check("rw_state", 32'(state_dbg), 32'(BUSY));
    check("rw_is_write", {30'd0, bus.mem_read, bus.mem_write}, 32'b01);
    check("rw_wdata", 32'(bus.mem_wdata), 32'h1234);
    check("rw_addr", 32'(bus.mem_address), 32'h0042);
    wait_resp("rw", n);
    check("rw_resp", 32'(bus.ch_resp), 32'b0001);
    bus.ch_read  = '0;
    bus.ch_write = '0;
    step();
    step();

    // contention from reset: ch0 then ch1, one RELEASE between
    do_reset();
    mem_lat           = 2;
    bus.ch_address[0] = 16'h1000;
    bus.ch_address[1] = 16'h2000;
    bus.ch_read       = 4'b0011;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    step();
    check("ct_grant0", 32'(grant_dbg), 32'd0);
    check("ct_addr0", 32'(bus.mem_address), 32'h1000);
    wait_resp("ct0", n);
    check("ct_resp0", 32'(bus.ch_resp), 32'b0001);
    bus.ch_read = 4'b0010;
    step();
    check("ct_release", 32'(state_dbg), 32'(RELEASE));
    check("ct_rel_strobe", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    step();
    check("ct_idle", 32'(state_dbg), 32'(IDLE));
    step();
    check("ct_grant1", 32'(grant_dbg), 32'd1);
    check("ct_addr1", 32'(bus.mem_address), 32'h2000);
    wait_resp("ct1", n);
    check("ct_resp1", 32'(bus.ch_resp), 32'b0010);
    bus.ch_read = '0;
    step();
    step();

    // fairness and wrap: all four requesting, ch2 is a writer
    do_reset();
    mem_lat               = 1;
    mem_rd_val            = 16'hC0DE;
    for (int i = 0; i < NUM_CH; i++) bus.ch_address[i] = 16'h0A00 + 16'(i);
    bus.ch_wdata[2]       = 16'h5555;
    bus.ch_byte_enable[2] = 2'b11;
    bus.ch_read           = 4'b1011;
    bus.ch_write          = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      g = k % NUM_CH;
      exp_q.push_back(4'(1 << g));
      wait_busy("fr");
      check("fr_grant", 32'(grant_dbg), 32'(g));
      check("fr_addr", 32'(bus.mem_address), 32'h0A00 + 32'(g));
      check("fr_kind", {30'd0, bus.mem_read, bus.mem_write}, (g == 2) ? 32'b01 : 32'b10);
      wait_resp("fr", n);
      if (k == 7) begin
        bus.ch_read  = '0;
        bus.ch_write = '0;
      end
      step();
      check("fr_rr_ptr", 32'(rr_ptr_dbg), 32'((g + 1) % NUM_CH));
    end
    step();
    step();

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lc3b_mem_arbiter.md
LC3B_MEM_ARBITER -- requirements
Module: lc3b_mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2: number of client memory ports, legal range 2..8.
REQ-002 Parameter ADDR_W, default 16: address width.
REQ-003 Parameter DATA_W, default 16: data width, a multiple of 8.
REQ-004 Parameter MASK_W, default DATA_W/8: byte-enable width, derived, not overridden.
REQ-005 The block SHALL use one clock, clk; reset is rst_n, synchronous and active-low.
REQ-006 Port clk  in  1  rising-edge clock.
REQ-007 Port rst_n  in  1  synchronous active-low reset.
REQ-008 Port ch_read  in  NUM_CH  per-client read request, level, held until that client's ch_resp.
REQ-009 Port ch_write  in  NUM_CH  per-client write request, level, held until that client's ch_resp.
REQ-010 Port ch_byte_enable  in  NUM_CH x MASK_W  per-client write byte mask.
REQ-011 Port ch_address  in  NUM_CH x ADDR_W  per-client address.
REQ-012 Port ch_wdata  in  NUM_CH x DATA_W  per-client write data.
REQ-013 Port ch_resp  out  NUM_CH  per-client one-cycle completion pulse.
REQ-014 Port ch_rdata  out  DATA_W  read data, shared by all clients, valid only with ch_resp.
REQ-015 Port mem_read  out  1  read strobe to physical memory.
REQ-016 Port mem_write  out  1  write strobe to physical memory.
REQ-017 Port mem_byte_enable  out  MASK_W  write mask to memory.
REQ-018 Port mem_address  out  ADDR_W  memory address.
REQ-019 Port mem_wdata  out  DATA_W  memory write data.
REQ-020 Port mem_resp  in  1  memory completion pulse.
REQ-021 Port mem_rdata  in  DATA_W  memory read data, valid with mem_resp.

Function
REQ-022 FSM states SHALL be IDLE, BUSY, RELEASE.
REQ-023 IDLE: if any ch_read or ch_write bit is set, the arbiter SHALL grant one client by round-robin, starting the search at pointer rr_ptr, and go to BUSY on the next edge; otherwise it stays in IDLE.
REQ-024 At grant, the arbiter SHALL register the grant index, the operation, address, wdata and byte_enable.
REQ-025 If a client asserts ch_read and ch_write together, the arbiter SHALL treat the request as a write.
REQ-026 BUSY: mem_read or mem_write SHALL be 1 (exactly one) and all mem_* outputs SHALL be driven from the registered copies.
REQ-027 Request-to-strobe latency SHALL be exactly one cycle, from the IDLE cycle that sees the request to mem strobe high.
REQ-028 In the BUSY cycle with mem_resp=1, the arbiter SHALL assert ch_resp[grant]=1 combinationally, with ch_rdata=mem_rdata.
REQ-029 In that same mem_resp cycle, the next edge SHALL set rr_ptr to (grant+1) mod NUM_CH and go to RELEASE.
REQ-030 RELEASE: lasts one cycle; all strobes and ch_resp SHALL be 0 and requests are ignored; next state is IDLE.
REQ-031 mem_resp outside BUSY SHALL be ignored.
REQ-032 Outside the mem_resp cycle in BUSY, all ch_resp bits SHALL be 0.
REQ-033 ch_rdata SHALL pass mem_rdata through at all times; clients sample it only with ch_resp.
REQ-034 A client dropping its request during BUSY is illegal; the arbiter SHALL still complete the transaction and pulse that client's ch_resp.
REQ-035 Fairness: with all clients continuously requesting, each client SHALL be granted once per NUM_CH transactions.
REQ-036 Grant wrap-around: rr_ptr SHALL wrap from NUM_CH-1 to 0.

Reset
REQ-037 While rst_n=0 at a clk edge, state SHALL go to IDLE and rr_ptr to 0.
REQ-038 Reset SHALL clear mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, ch_resp and the grant registers to 0.
REQ-039 Reset during BUSY SHALL abandon the transaction with no ch_resp, and strobes SHALL be 0 in the cycle after the edge.

Structure
REQ-040 The FSM state enum and the default width constants SHALL live in package lc3b_types.
REQ-041 Round-robin selection SHALL be a combinational sub-module, rr_picker (inputs req vector and ptr; outputs valid and index).

Verification
REQ-042 Single read: ch_read[1]=1, addr 0x1234, mem returns 0xBEEF after 3 cycles -> mem_read high one cycle after request, mem_address=0x1234, ch_resp[1] pulses once with ch_rdata=0xBEEF.
REQ-043 Masked write: ch_write[0], addr 0x0041, wdata 0xAB00, mask 2'b10 -> mem_write, mem_byte_enable=2'b10, mem_wdata=0xAB00, ch_resp[0] pulses.
REQ-044 Contention: both channels request in the same cycle from reset (rr_ptr=0) -> ch0 served first, then ch1, with one RELEASE cycle between.
REQ-045 Fairness and wrap: NUM_CH=4, all channels requesting continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-046 Reset mid-BUSY: rst_n=0 while mem_read=1 -> strobes 0 next cycle, no ch_resp, rr_ptr=0.
REQ-047 Read+write on ch0 together with a stray mem_resp in IDLE -> the stray mem_resp is ignored and a write is issued.
